// File: rtl/out_port_arbiter_if.sv
// Byte-share bus between internal requesters and the output-port arbiter.
// The master side offers bytes; the slave side is the arbiter driving the output byte.
interface out_port_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int SW = $clog2(N_REQ);

    logic                   en;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*DW-1:0]    req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [DW-1:0]          out_data;
    logic                   out_strobe;
    logic [SW-1:0]          out_src;
    logic                   busy;

    modport master (
        output en, req_valid, req_data,
        input  req_ready, out_data, out_strobe, out_src, busy
    );

    modport slave (
        input  en, req_valid, req_data,
        output req_ready, out_data, out_strobe, out_src, busy
    );
endinterface

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing one registered output byte between N_REQ requesters,
// with a fixed HOLD-cycle dwell after every transfer.
module out_port_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int HOLD  = 4
) (
    input  logic               clk,
    input  logic               rst,
    out_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(N_REQ);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t           state;
    state_t           next_state;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    grant_idx;
    logic [SW:0]      scan;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    next_cnt;
    logic             found;
    logic             fire;
    logic [N_REQ-1:0] ready;
    logic [DW-1:0]    data_q;
    logic             strobe_q;
    logic [SW-1:0]    src_q;

    // Scan starts at ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr} + (SW+1)'(k);
            if (scan >= (SW+1)'(N_REQ)) begin
                scan = scan - (SW+1)'(N_REQ);
            end
            if (!found && bus.req_valid[scan[SW-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan[SW-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (!rst && state == S_IDLE && bus.en && found) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign fire = |(bus.req_valid & ready);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (fire) begin
                    next_state = S_HOLD;
                    next_cnt   = CW'(HOLD - 1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    next_state = S_IDLE;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            src_q    <= '0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            strobe_q <= fire;
            if (fire) begin
                data_q <= bus.req_data[grant_idx*DW +: DW];
                src_q  <= grant_idx;
                ptr    <= (grant_idx == SW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // out_data and out_src keep the last transfer until the next one replaces it.
    assign bus.req_ready  = ready;
    assign bus.out_data   = data_q;
    assign bus.out_strobe = strobe_q;
    assign bus.out_src    = src_q;
    assign bus.busy       = (state == S_HOLD);
endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: a per-cycle vector table plus hand-written
// sequences for round-robin rotation, enable gating and reset during HOLD.
module tb_out_port_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    out_port_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    out_port_arbiter #(.N_REQ(N_REQ), .DW(DW), .HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] v;
        logic [3:0] ready;
        logic [7:0] data;
        logic       strobe;
        logic [1:0] src;
        logic       busy;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    vec_t tbl [19];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] v);
        @(posedge clk);
        #1;
        rst           = r;
        bus.en        = e;
        bus.req_valid = v;
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000);
    endtask

    initial begin
        int          n;
        logic        prev_strobe;
        logic [31:0] exp_cyc  [5];
        logic [31:0] exp_data [5];

        bus.en        = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = {8'h43, 8'hA5, 8'h21, 8'h10};

        //               r     e     v        ready    data   stb   src    busy
        tbl[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b1, 2'd2, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 4'b0010, 4'b0010, 8'hA5, 1'b0, 2'd2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 8'h21, 1'b1, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 8'h21, 1'b0, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 8'h21, 1'b0, 2'd1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'b0011, 4'b0000, 8'h21, 1'b0, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'b0011, 4'b0001, 8'h21, 1'b0, 2'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'h10, 1'b1, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 4'b0001, 4'b0000, 8'h10, 1'b0, 2'd0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'h10, 1'b0, 2'd0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'h10, 1'b0, 2'd0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 4'b1000, 4'b0000, 8'h10, 1'b0, 2'd0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 8'h10, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'h43, 1'b1, 2'd3, 1'b1};

        doReset();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i].r, tbl[i].e, tbl[i].v);
            checkOutput($sformatf("tbl%0d_ready", i),  32'(bus.req_ready),  32'(tbl[i].ready));
            checkOutput($sformatf("tbl%0d_data", i),   32'(bus.out_data),   32'(tbl[i].data));
            checkOutput($sformatf("tbl%0d_strobe", i), 32'(bus.out_strobe), 32'(tbl[i].strobe));
            checkOutput($sformatf("tbl%0d_src", i),    32'(bus.out_src),    32'(tbl[i].src));
            checkOutput($sformatf("tbl%0d_busy", i),   32'(bus.busy),       32'(tbl[i].busy));
        end

        // All four requesters valid continuously: rotation 0,1,2,3 then wrap to 0.
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        exp_cyc  = '{32'd1, 32'd6, 32'd11, 32'd16, 32'd21};
        exp_data = '{32'h10, 32'h21, 32'h32, 32'h43, 32'h10};
        doReset();
        n = 0;
        prev_strobe = 1'b0;
        for (int cyc = 0; cyc < 23; cyc++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111);
            if (bus.out_strobe) begin
                checkOutput("rr_no_consec_strobe", 32'(prev_strobe), 32'd0);
                if (n < 5) begin
                    checkOutput($sformatf("rr%0d_cycle", n), 32'(cyc), exp_cyc[n]);
                    checkOutput($sformatf("rr%0d_data", n), 32'(bus.out_data), exp_data[n]);
                end
                n++;
            end
            prev_strobe = bus.out_strobe;
        end
        checkOutput("rr_strobe_count", 32'(n), 32'd5);

        // en=0 blocks grants and leaves ptr alone; ptr is 3 after granting requester 2.
        doReset();
        applyStimulus(1'b0, 1'b1, 4'b0100);
        repeat (5) applyStimulus(1'b0, 1'b1, 4'b0000);
        n = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            applyStimulus(1'b0, 1'b0, 4'b1111);
            if (bus.req_ready != 4'b0000 || bus.out_strobe != 1'b0) n++;
        end
        checkOutput("en0_quiet_cycles", 32'(n), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'b1111);
        checkOutput("en1_ready", 32'(bus.req_ready), 32'b1000);
        applyStimulus(1'b0, 1'b1, 4'b0000);
        checkOutput("en1_strobe", 32'(bus.out_strobe), 32'd1);
        checkOutput("en1_src",    32'(bus.out_src),    32'd3);
        checkOutput("en1_data",   32'(bus.out_data),   32'h43);

        // Reset two cycles into HOLD abandons the transfer and restarts the scan at 0.
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'hFF};
        doReset();
        applyStimulus(1'b0, 1'b1, 4'b0001);
        applyStimulus(1'b0, 1'b1, 4'b0000);
        checkOutput("rsth_data",   32'(bus.out_data),   32'hFF);
        checkOutput("rsth_strobe", 32'(bus.out_strobe), 32'd1);
        applyStimulus(1'b1, 1'b1, 4'b1001);
        checkOutput("rsth_ready_in_rst", 32'(bus.req_ready), 32'd0);
        checkOutput("rsth_busy_before",  32'(bus.busy),      32'd1);
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'h5A};
        applyStimulus(1'b1, 1'b1, 4'b1001);
        checkOutput("rsth_data_clr", 32'(bus.out_data),   32'h00);
        checkOutput("rsth_busy_clr", 32'(bus.busy),       32'd0);
        checkOutput("rsth_strb_clr", 32'(bus.out_strobe), 32'd0);
        checkOutput("rsth_ready_0",  32'(bus.req_ready),  32'd0);
        applyStimulus(1'b0, 1'b1, 4'b1001);
        checkOutput("rsth_regrant_ready", 32'(bus.req_ready), 32'b0001);
        applyStimulus(1'b0, 1'b1, 4'b0000);
        checkOutput("rsth_regrant_data", 32'(bus.out_data),   32'h5A);
        checkOutput("rsth_regrant_src",  32'(bus.out_src),    32'd0);
        checkOutput("rsth_regrant_stb",  32'(bus.out_strobe), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
